// File: rtl/procyon_ccu_mhq_sched_pkg.sv
// Shared types for the CCU miss handling queue scheduler.
package procyon_ccu_mhq_sched_pkg;

  localparam int unsigned MHQ_SCHED_STATE_WIDTH = 2;

  typedef enum logic [MHQ_SCHED_STATE_WIDTH-1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10
  } mhq_sched_state_t;

endpackage

// File: rtl/procyon_ccu_mhq_age_fifo.sv
// Circular FIFO of allocated MHQ indices in allocation order; head is the oldest
// entry not yet requested from the CCU.
module procyon_ccu_mhq_age_fifo #(
  parameter int unsigned OPTN_MHQ_DEPTH = 4,
  parameter int unsigned MHQ_IDX_WIDTH  = $clog2(OPTN_MHQ_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [MHQ_IDX_WIDTH-1:0] i_push_idx,
  input  logic                     i_pop,
  output logic [MHQ_IDX_WIDTH-1:0] o_head_idx,
  output logic                     o_empty
);

  localparam int unsigned PtrWidth = MHQ_IDX_WIDTH + 1;

  logic [MHQ_IDX_WIDTH-1:0] fifo_q [OPTN_MHQ_DEPTH];
  logic [PtrWidth-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]      rd_ptr_q, rd_ptr_d;
  logic                     full;
  logic                     push_en;
  logic                     pop_en;

  // Extra pointer bit tells a full FIFO apart from an empty one.
  always_comb begin
    o_empty  = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[MHQ_IDX_WIDTH] != rd_ptr_q[MHQ_IDX_WIDTH]) &&
               (wr_ptr_q[MHQ_IDX_WIDTH-1:0] == rd_ptr_q[MHQ_IDX_WIDTH-1:0]);
    push_en  = i_push & ~full;
    pop_en   = i_pop & ~o_empty;
    wr_ptr_d = push_en ? wr_ptr_q + PtrWidth'(1) : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + PtrWidth'(1) : rd_ptr_q;
    o_head_idx = fifo_q[rd_ptr_q[MHQ_IDX_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_q[wr_ptr_q[MHQ_IDX_WIDTH-1:0]] <= i_push_idx;
    end
  end

endmodule

// File: rtl/procyon_ccu_mhq_sched.sv
// MHQ allocate/merge routing, single-outstanding CCU fetch sequencing and fill select.
// Define PCYN_MHQ_SCHED_AGE_ORDER_EN to fetch oldest-first instead of lowest-index-first.
module procyon_ccu_mhq_sched
  import procyon_ccu_mhq_sched_pkg::*;
#(
  parameter int unsigned OPTN_MHQ_DEPTH = 4,
  parameter int unsigned MHQ_IDX_WIDTH  = $clog2(OPTN_MHQ_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OPTN_MHQ_DEPTH-1:0] i_mhq_entry_valid,
  input  logic [OPTN_MHQ_DEPTH-1:0] i_mhq_entry_complete,
  input  logic [OPTN_MHQ_DEPTH-1:0] i_lookup_hit,
  input  logic                      i_lsu_miss_en,
  output logic                      o_lsu_retry,
  output logic [OPTN_MHQ_DEPTH-1:0] o_update_en,
  output logic                      o_mhq_full,
  output logic                      o_ccu_req_valid,
  output logic [MHQ_IDX_WIDTH-1:0]  o_ccu_req_idx,
  input  logic                      i_ccu_req_ack,
  input  logic                      i_ccu_done,
  output logic [OPTN_MHQ_DEPTH-1:0] o_ccu_done,
  output logic                      o_fill_valid,
  output logic [MHQ_IDX_WIDTH-1:0]  o_fill_idx,
  input  logic                      i_fill_ack,
  output logic [OPTN_MHQ_DEPTH-1:0] o_fill_launched
);

  function automatic logic [OPTN_MHQ_DEPTH-1:0] onehot(input logic [MHQ_IDX_WIDTH-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic logic [MHQ_IDX_WIDTH-1:0] lsb_idx(input logic [OPTN_MHQ_DEPTH-1:0] vec);
    lsb_idx = '0;
    for (int i = OPTN_MHQ_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) lsb_idx = MHQ_IDX_WIDTH'(i);
    end
  endfunction

  mhq_sched_state_t          state_q, state_d;
  logic [MHQ_IDX_WIDTH-1:0]  req_idx_q, req_idx_d;
  logic [OPTN_MHQ_DEPTH-1:0] issued_q, issued_d;
  logic [OPTN_MHQ_DEPTH-1:0] pending;
  logic [MHQ_IDX_WIDTH-1:0]  free_idx;
  logic                      hit_any;
  logic                      merge_conflict;
  logic                      req_ack_fire;
  logic                      cand_valid;
  logic [MHQ_IDX_WIDTH-1:0]  cand_idx;

  // Fill select: lowest complete entry, launched in the same cycle as the ack.
  always_comb begin
    o_fill_valid    = |i_mhq_entry_complete;
    o_fill_idx      = lsb_idx(i_mhq_entry_complete);
    o_fill_launched = (o_fill_valid && i_fill_ack) ? onehot(o_fill_idx) : '0;
  end

  // Allocation uses current entry state only; slots freed this cycle are not reused.
  always_comb begin
    o_mhq_full     = &i_mhq_entry_valid;
    free_idx       = lsb_idx(~i_mhq_entry_valid);
    hit_any        = |i_lookup_hit;
    merge_conflict = |(i_lookup_hit & o_fill_launched);
    o_update_en    = '0;
    o_lsu_retry    = 1'b0;
    if (i_lsu_miss_en) begin
      if (hit_any) begin
        if (merge_conflict) o_lsu_retry = 1'b1;
        else                o_update_en = i_lookup_hit;
      end else if (!o_mhq_full) begin
        o_update_en = onehot(free_idx);
      end else begin
        o_lsu_retry = 1'b1;
      end
    end
  end

  assign pending = i_mhq_entry_valid & ~issued_q & ~i_mhq_entry_complete;

`ifdef PCYN_MHQ_SCHED_AGE_ORDER_EN
  logic                     alloc_push;
  logic [MHQ_IDX_WIDTH-1:0] fifo_head;
  logic                     fifo_empty;

  assign alloc_push = i_lsu_miss_en & ~hit_any & ~o_mhq_full;

  procyon_ccu_mhq_age_fifo #(
    .OPTN_MHQ_DEPTH(OPTN_MHQ_DEPTH),
    .MHQ_IDX_WIDTH (MHQ_IDX_WIDTH)
  ) u_age_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (alloc_push),
    .i_push_idx(free_idx),
    .i_pop     (req_ack_fire),
    .o_head_idx(fifo_head),
    .o_empty   (fifo_empty)
  );

  assign cand_valid = (|pending) & ~fifo_empty;
  assign cand_idx   = fifo_head;
`else
  assign cand_valid = |pending;
  assign cand_idx   = lsb_idx(pending);
`endif

  always_comb begin
    state_d         = state_q;
    req_idx_d       = req_idx_q;
    req_ack_fire    = 1'b0;
    o_ccu_req_valid = 1'b0;
    o_ccu_done      = '0;
    unique case (state_q)
      StIdle: begin
        if (cand_valid) begin
          req_idx_d = cand_idx;
          state_d   = StReq;
        end
      end
      StReq: begin
        o_ccu_req_valid = 1'b1;
        if (i_ccu_req_ack) begin
          req_ack_fire = 1'b1;
          state_d      = StWait;
        end
      end
      StWait: begin
        if (i_ccu_done) begin
          o_ccu_done = onehot(req_idx_q);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_ccu_req_idx = req_idx_q;

  // A fill launch frees the entry, so its issued mark must not outlive it.
  always_comb begin
    issued_d = issued_q;
    if (req_ack_fire) issued_d = issued_d | onehot(req_idx_q);
    issued_d = issued_d & ~o_fill_launched;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      req_idx_q <= '0;
      issued_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_idx_q <= req_idx_d;
      issued_q  <= issued_d;
    end
  end

endmodule
